// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter giving N requesters locked write access to one shared W-bit register.
// An owner keeps the register for up to MAX_BURST writes; a release re-arbitrates in the same edge.
module reg_bank_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [2:0]     owner,
  output logic           busy
);

  localparam logic [2:0] LAST_IDX    = 3'(N - 1);
  localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] gnt_reg, gnt_next;
  logic [W-1:0] q_reg, q_next;
  logic         q_valid_reg, q_valid_next;
  logic [2:0]   owner_reg, owner_next;
  logic [2:0]   ptr_reg, ptr_next;
  logic [3:0]   burst_cnt_reg, burst_cnt_next;

  logic [7:0]   req_ext, lock_ext, arb_mask;
  logic [W-1:0] wdata_arr [8];
  logic [2:0]   arb_start, arb_winner, search_idx, owner_inc;
  logic         arb_found;
  logic [N-1:0] winner_onehot;
  logic         write_en, keep_own, release_own;
  logic [4:0]   cnt_inc;

  // Widen per-requester inputs to 8 lanes so a 3-bit owner index is always in range.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < N) begin : g_used
        assign req_ext[gi]   = req[gi];
        assign lock_ext[gi]  = lock[gi];
        assign wdata_arr[gi] = wdata[gi*W +: W];
      end else begin : g_unused
        assign req_ext[gi]   = 1'b0;
        assign lock_ext[gi]  = 1'b0;
        assign wdata_arr[gi] = '0;
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign winner_onehot[gi] = (arb_winner == 3'(gi));
    end
  endgenerate

  assign write_en    = (state_reg == OWN) && req_ext[owner_reg];
  assign cnt_inc     = {1'b0, burst_cnt_reg} + 5'd1;
  assign keep_own    = write_en && lock_ext[owner_reg] && (cnt_inc < BURST_LIMIT);
  assign release_own = (state_reg == OWN) && !keep_own;
  assign owner_inc   = (owner_reg == LAST_IDX) ? 3'd0 : owner_reg + 3'd1;

  // A releasing owner is masked out and the search starts just above it.
  always_comb begin
    arb_mask  = req_ext;
    arb_start = ptr_reg;
    if (state_reg == OWN) begin
      arb_mask[owner_reg] = 1'b0;
      arb_start           = owner_inc;
    end
  end

  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    search_idx = arb_start;
    for (int k = 0; k < N; k++) begin
      if (!arb_found && arb_mask[search_idx]) begin
        arb_found  = 1'b1;
        arb_winner = search_idx;
      end
      search_idx = (search_idx == LAST_IDX) ? 3'd0 : search_idx + 3'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_found) state_next = OWN;
      OWN:     if (release_own && !arb_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next       = gnt_reg;
    q_next         = q_reg;
    q_valid_next   = write_en;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    if (write_en) begin
      q_next         = wdata_arr[owner_reg];
      burst_cnt_next = cnt_inc[3:0];
    end
    if (release_own) begin
      ptr_next = owner_inc;
    end
    if ((state_reg == IDLE) || release_own) begin
      if (arb_found) begin
        owner_next     = arb_winner;
        gnt_next       = winner_onehot;
        burst_cnt_next = '0;
      end else if (release_own) begin
        gnt_next       = '0;
        burst_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg       <= '0;
      q_reg         <= '0;
      q_valid_reg   <= 1'b0;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      burst_cnt_reg <= '0;
    end else begin
      gnt_reg       <= gnt_next;
      q_reg         <= q_next;
      q_valid_reg   <= q_valid_next;
      owner_reg     <= owner_next;
      ptr_reg       <= ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Output logic
  always_comb begin
    gnt     = gnt_reg;
    q       = q_reg;
    q_valid = q_valid_reg;
    owner   = owner_reg;
    busy    = (state_reg == OWN);
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_reg));
  a_busy_gnt:    assert property (@(posedge clk) disable iff (rst) busy == (gnt_reg != '0));

endmodule
